spi_reg_bridge: RTL and testbench
=================================

Name: spi_reg_bridge

Overview:
- SPI slave (SCLK/MOSI/MISO/CS) sampled entirely in the system clock domain.
- Generalises the single-register receiver into an addressed bank of NUM_REGS user registers, each DATA_W wide, with write, read-back and burst auto-increment.
- Keeps a stream mode that feeds INSTR_W-bit instruction words to the shader memory.
- Sits between the chip pins and the shader core / configuration logic.

Parameters:
- DATA_W, 8: width of each user register and of a register-mode data word.
- NUM_REGS, 4: number of user registers; range 1..128.
- INSTR_W, 8: width of a stream-mode word.
- SAMPLE_FALLING, 1: 1 = sample MOSI on SCLK falling edge and launch MISO on rising; 0 = swapped.
- REG_DEFAULT, '0: reset value of every register, DATA_W bits.

Ports:
- clk_i  in  1  system clock (the one clock).
- rst_i  in  1  asynchronous, active-high reset.
- spi_sclk_i  in  1  SPI clock (asynchronous).
- spi_mosi_i  in  1  SPI data in (asynchronous).
- spi_cs_i  in  1  chip select, active low (asynchronous).
- spi_miso_o  out  1  SPI data out.
- mode_i  in  1  0 = register mode, 1 = stream mode (asynchronous).
- memory_instr_o  out  INSTR_W  last complete stream word.
- memory_load_o  out  1  one-cycle pulse when a stream word completes.
- user_o  out  NUM_REGS*DATA_W  flattened registers; reg k at [k*DATA_W +: DATA_W].
- wr_strobe_o  out  NUM_REGS  one-cycle pulse on the bit of the register just written.

Behaviour:
- Input sync: sclk, mosi, cs and mode each pass through a 2-FF synchronizer. SCLK edge detection uses one extra delay FF.
- "Sample edge" and "launch edge" are single-cycle detected pulses, qualified by synchronized CS low.
- Reset values: all registers = REG_DEFAULT; spi_miso_o, memory_load_o, wr_strobe_o = 0; memory_instr_o = 0; FSM = IDLE; counters = 0.
- Reset is honoured mid-frame with no partial commit.
- FSM states: IDLE, CMD, DATA, STREAM.
  - IDLE -> on synchronized CS falling: latch mode_sync as frame mode. Go to STREAM if the mode is 1, else CMD.
  - Mode is frozen for the rest of the frame; mode_i changes mid-frame are ignored.
  - CMD: shift 8 bits, MSB first. Bit7 = write(1)/read(0); bits[6:0] = address. After the 8th sample go to DATA and clear the bit counter.
  - DATA: shift DATA_W bits. On the sample edge of the last bit, in the same clk cycle:
    - write with addr < NUM_REGS: reg[addr] <= {shift[DATA_W-2:0], mosi}; wr_strobe_o[addr] pulses the next cycle.
    - write with addr >= NUM_REGS: word silently dropped, no strobe.
    - then addr <= addr+1 (7-bit wrap, 127 -> 0), reload the read word, stay in DATA (burst).
  - STREAM: shift INSTR_W bits. On the last sample, memory_instr_o <= completed word and memory_load_o pulses one cycle. The counter wraps and streaming continues.
- CS rising (synchronized) in any state -> IDLE in the next cycle; partial words discarded, no strobes, no pulses.
- MISO, updated only on launch edges while CS is low:
  - CMD phase: 0.
  - DATA phase, read: reg[addr] MSB first; the first bit is launched on the first launch edge after the command completes. Out-of-range address reads all zeros.
  - DATA phase, write: echoes the MSB of the shift register.
  - STREAM: echoes the MSB of the shift register.
  - MISO holds its value while CS is high.
- Widths: bit counter = $clog2(max(8, DATA_W, INSTR_W)). Address 7 bits, indexed into the bank with a range check.
- A sample edge and a CS rise in the same cycle: CS rise wins, the sample is discarded.

Decomposition:
- Package spi_reg_bridge_pkg: state enum (IDLE, CMD, DATA, STREAM), CMD_W = 8, CMD_WRITE_BIT = 7, ADDR_W = 7.
- Reuse the existing synchronizer sub-module (FF_COUNT = 2), reset port driven by !rst_i.
- One natural new sub-module, spi_edge_detect: sync-delay FF plus rising/falling pulse generation, selected by SAMPLE_FALLING.

Test Plan:
- Reset (rst_i = 1 mid-frame) -> user_o = all REG_DEFAULT, outputs 0, the next frame decodes from a clean CMD.
- Write frame cmd 0x82, data 0xA5 (defaults) -> reg2 = 0xA5, wr_strobe_o = 4'b0100 for exactly one cycle, other regs unchanged.
- Burst write cmd 0x83, data 0x11, 0x22 -> reg3 = 0x11, then address wraps past NUM_REGS (addr 4 dropped, no strobe); reg0 unchanged.
- Read frame cmd 0x02 after the write above -> MISO returns 1010_0101 MSB first; read cmd 0x10 (out of range) -> 0x00.
- Stream mode, mode_i = 1, bytes 0x3C, 0xF0 -> two memory_load_o pulses with memory_instr_o = 0x3C, then 0xF0; toggling mode_i mid-frame has no effect.
- Abort: CS raised after 5 data bits of a write to reg1 -> reg1 unchanged, no strobe; the next full frame writes correctly. Repeat with SAMPLE_FALLING = 0.

Source files
------------

// File: rtl/spi_reg_bridge_pkg.sv
// Shared types and constants for the SPI register bridge.
package spi_reg_bridge_pkg;

  // Frame-level protocol states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    DATA   = 2'd2,
    STREAM = 2'd3
  } state_e;

  localparam int CMD_W         = 8;
  localparam int CMD_WRITE_BIT = 7;
  localparam int ADDR_W        = 7;
  localparam int SYNC_FF_COUNT = 2;

  // Largest of three widths, used to size the common shift register.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/spi_edge_detect.sv
// Turns the synchronized SPI clock into single-cycle sample/launch pulses,
// both gated by an active (low) synchronized chip select.
module spi_edge_detect #(
  parameter bit SAMPLE_FALLING = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sclk_i,
  input  logic cs_n_i,
  output logic sample_o,
  output logic launch_o
);

  logic sclk_dly_q;
  logic sclk_dly_d;
  logic sclk_rise;
  logic sclk_fall;

  // One-cycle delayed copy of the synchronized clock.
  always_comb begin
    sclk_dly_d = sclk_i;
  end

  // Delay flop; resets low to match the synchronizer reset level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_dly_q <= 1'b0;
    end else begin
      sclk_dly_q <= sclk_dly_d;
    end
  end

  assign sclk_rise = sclk_i & ~sclk_dly_q;
  assign sclk_fall = ~sclk_i & sclk_dly_q;

  generate
    if (SAMPLE_FALLING) begin : g_sample_fall
      assign sample_o = sclk_fall & ~cs_n_i;
      assign launch_o = sclk_rise & ~cs_n_i;
    end else begin : g_sample_rise
      assign sample_o = sclk_rise & ~cs_n_i;
      assign launch_o = sclk_fall & ~cs_n_i;
    end
  endgenerate

endmodule

// File: rtl/synchronizer.sv
// Multi-flop synchronizer bringing one asynchronous bit into the clk_i domain.
module synchronizer #(
  parameter int   FF_COUNT  = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [FF_COUNT-1:0] sync_q;
  logic [FF_COUNT-1:0] sync_d;

  // Advance the asynchronous input one stage along the chain.
  always_comb begin
    sync_d = {sync_q[FF_COUNT-2:0], d_i};
  end

  // Chain flops; the reset value keeps the output at the pin's idle level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {FF_COUNT{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[FF_COUNT-1];

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI slave bridging pin-level SPI to an addressed user register bank
// (write, read-back, burst auto-increment) and an instruction stream port.
module spi_reg_bridge
  import spi_reg_bridge_pkg::*;
#(
  parameter int               DATA_W         = 8,
  parameter int               NUM_REGS       = 4,
  parameter int               INSTR_W        = 8,
  parameter bit               SAMPLE_FALLING = 1'b1,
  parameter logic [DATA_W-1:0] REG_DEFAULT   = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         spi_sclk_i,
  input  logic                         spi_mosi_i,
  input  logic                         spi_cs_i,
  output logic                         spi_miso_o,
  input  logic                         mode_i,
  output logic [INSTR_W-1:0]           memory_instr_o,
  output logic                         memory_load_o,
  output logic [NUM_REGS*DATA_W-1:0]   user_o,
  output logic [NUM_REGS-1:0]          wr_strobe_o
);

  localparam int SHIFT_W = max3(CMD_W, DATA_W, INSTR_W);
  localparam int CNT_W   = $clog2(SHIFT_W);
  localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int BANK_W  = NUM_REGS * DATA_W;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] INSTR_LAST = CNT_W'(INSTR_W - 1);

  // Index order of the synchronized pins; CS idles high, the rest low.
  localparam logic [3:0] SYNC_RESET = 4'b0100;

  logic       rst_n;
  logic [3:0] async_in;
  logic [3:0] sync_out;
  logic       sclk_sync;
  logic       mosi_sync;
  logic       cs_sync;
  logic       mode_sync;
  logic       sample;
  logic       launch;
  logic       cs_fall;
  logic       cs_rise;

  assign rst_n    = ~rst_i;
  assign async_in = {mode_i, spi_cs_i, spi_mosi_i, spi_sclk_i};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      synchronizer #(
        .FF_COUNT (SYNC_FF_COUNT),
        .RESET_VAL(SYNC_RESET[gi])
      ) u_sync (
        .clk_i (clk_i),
        .rst_ni(rst_n),
        .d_i   (async_in[gi]),
        .q_o   (sync_out[gi])
      );
    end
  endgenerate

  assign sclk_sync = sync_out[0];
  assign mosi_sync = sync_out[1];
  assign cs_sync   = sync_out[2];
  assign mode_sync = sync_out[3];

  spi_edge_detect #(
    .SAMPLE_FALLING(SAMPLE_FALLING)
  ) u_edge (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .sclk_i  (sclk_sync),
    .cs_n_i  (cs_sync),
    .sample_o(sample),
    .launch_o(launch)
  );

  state_e               state_q,    state_d;
  logic [CNT_W-1:0]     cnt_q,      cnt_d;
  logic [SHIFT_W-1:0]   shift_q,    shift_d;
  logic [DATA_W-1:0]    rd_shift_q, rd_shift_d;
  logic [ADDR_W-1:0]    addr_q,     addr_d;
  logic                 wr_q,       wr_d;
  logic                 miso_q,     miso_d;
  logic [INSTR_W-1:0]   instr_q,    instr_d;
  logic                 load_q,     load_d;
  logic [NUM_REGS-1:0]  strobe_q,   strobe_d;
  logic [BANK_W-1:0]    user_q,     user_d;
  logic                 cs_prev_q,  cs_prev_d;

  logic [SHIFT_W-1:0]   shift_in;
  logic [ADDR_W-1:0]    cmd_addr;
  logic [ADDR_W-1:0]    addr_next;
  logic [IDX_W-1:0]     addr_idx;
  logic                 addr_ok;

  assign cs_fall   = cs_prev_q & ~cs_sync;
  assign cs_rise   = ~cs_prev_q & cs_sync;
  assign shift_in  = {shift_q[SHIFT_W-2:0], mosi_sync};
  assign cmd_addr  = shift_in[ADDR_W-1:0];
  assign addr_next = addr_q + ADDR_W'(1);
  assign addr_idx  = addr_q[IDX_W-1:0];
  assign addr_ok   = (int'(addr_q) < NUM_REGS);

  // Read-side lookup; addresses outside the bank read as zero.
  function automatic logic [DATA_W-1:0] reg_word(input logic [BANK_W-1:0] bank,
                                                 input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    w = '0;
    if (int'(a) < NUM_REGS) begin
      w = bank[int'(a)*DATA_W +: DATA_W];
    end
    return w;
  endfunction

  // Frame decoder: next state, shifting, register commits and output pulses.
  // The frame mode is captured by the IDLE exit branch and is not revisited.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rd_shift_d = rd_shift_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    miso_d     = miso_q;
    instr_d    = instr_q;
    load_d     = 1'b0;
    strobe_d   = '0;
    user_d     = user_q;
    cs_prev_d  = cs_sync;

    if (cs_rise) begin
      // End of frame wins over any coincident sample; partial words are lost.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_d = mode_sync ? STREAM : CMD;
            cnt_d   = '0;
            shift_d = '0;
          end
        end

        CMD: begin
          if (launch) begin
            miso_d = 1'b0;
          end
          if (sample) begin
            shift_d = shift_in;
            if (cnt_q == CMD_LAST) begin
              cnt_d      = '0;
              state_d    = DATA;
              wr_d       = shift_in[CMD_WRITE_BIT];
              addr_d     = cmd_addr;
              rd_shift_d = reg_word(user_q, cmd_addr);
              shift_d    = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end

        DATA: begin
          if (launch) begin
            if (wr_q) begin
              miso_d = shift_q[DATA_W-1];
            end else begin
              miso_d     = rd_shift_q[DATA_W-1];
              rd_shift_d = {rd_shift_q[DATA_W-2:0], 1'b0};
            end
          end
          if (sample) begin
            shift_d = shift_in;
            if (cnt_q == DATA_LAST) begin
              cnt_d = '0;
              if (wr_q && addr_ok) begin
                user_d[int'(addr_idx)*DATA_W +: DATA_W] = shift_in[DATA_W-1:0];
                strobe_d[addr_idx] = 1'b1;
              end
              addr_d     = addr_next;
              rd_shift_d = reg_word(user_q, addr_next);
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end

        STREAM: begin
          if (launch) begin
            miso_d = shift_q[INSTR_W-1];
          end
          if (sample) begin
            shift_d = shift_in;
            if (cnt_q == INSTR_LAST) begin
              cnt_d   = '0;
              instr_d = shift_in[INSTR_W-1:0];
              load_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // All protocol state, the register bank and the registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      rd_shift_q <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      miso_q     <= 1'b0;
      instr_q    <= '0;
      load_q     <= 1'b0;
      strobe_q   <= '0;
      user_q     <= {NUM_REGS{REG_DEFAULT}};
      cs_prev_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rd_shift_q <= rd_shift_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      miso_q     <= miso_d;
      instr_q    <= instr_d;
      load_q     <= load_d;
      strobe_q   <= strobe_d;
      user_q     <= user_d;
      cs_prev_q  <= cs_prev_d;
    end
  end

  assign spi_miso_o     = miso_q;
  assign memory_instr_o = instr_q;
  assign memory_load_o  = load_q;
  assign user_o         = user_q;
  assign wr_strobe_o    = strobe_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Randomized frame-level bench for spi_reg_bridge; two instances (sample on
// falling / sample on rising with inverted SCLK) share one reference model.
module tb_spi_reg_bridge;

  localparam int NR = 4;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        cs   = 1'b1;
  logic        mode = 1'b0;
  logic        sclk_n;
  logic        miso_f, miso_r, load_f, load_r;
  logic [7:0]  instr_f, instr_r;
  logic [31:0] user_f, user_r;
  logic [3:0]  strb_f, strb_r;

  assign sclk_n = ~sclk;

  always #5 clk = ~clk;

  spi_reg_bridge #(
    .DATA_W(8), .NUM_REGS(NR), .INSTR_W(8), .SAMPLE_FALLING(1'b1), .REG_DEFAULT(8'h00)
  ) dut_f (
    .clk_i(clk), .rst_i(rst), .spi_sclk_i(sclk), .spi_mosi_i(mosi), .spi_cs_i(cs),
    .spi_miso_o(miso_f), .mode_i(mode), .memory_instr_o(instr_f), .memory_load_o(load_f),
    .user_o(user_f), .wr_strobe_o(strb_f)
  );

  spi_reg_bridge #(
    .DATA_W(8), .NUM_REGS(NR), .INSTR_W(8), .SAMPLE_FALLING(1'b0), .REG_DEFAULT(8'h00)
  ) dut_r (
    .clk_i(clk), .rst_i(rst), .spi_sclk_i(sclk_n), .spi_mosi_i(mosi), .spi_cs_i(cs),
    .spi_miso_o(miso_r), .mode_i(mode), .memory_instr_o(instr_r), .memory_load_o(load_r),
    .user_o(user_r), .wr_strobe_o(strb_r)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_f[$], rx_r[$];
  logic [3:0] mon_strb_f[$], mon_strb_r[$];
  logic [7:0] mon_ld_f[$], mon_ld_r[$];
  logic [3:0] exp_strb[$];
  logic [7:0] exp_ld[$], exp_rx[$];
  logic [7:0] mregs[NR];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Event capture for the one-cycle pulse outputs.
  always @(negedge clk) begin
    if (!rst) begin
      if (strb_f != 4'h0) mon_strb_f.push_back(strb_f);
      if (strb_r != 4'h0) mon_strb_r.push_back(strb_r);
      if (load_f) mon_ld_f.push_back(instr_f);
      if (load_r) mon_ld_r.push_back(instr_r);
    end
  end

  // Drive one CS-low frame of nbits from tx_q; optional mode toggle / reset.
  task automatic do_frame(input bit md, input int nbits, input int toggle_at, input int rst_at);
    logic [7:0] bf, br, b;
    bf = 8'h00;
    br = 8'h00;
    rx_f.delete(); rx_r.delete();
    mon_strb_f.delete(); mon_strb_r.delete(); mon_ld_f.delete(); mon_ld_r.delete();
    mode = md;
    wait_clk(3);
    cs = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        break;
      end
      if (i == toggle_at) mode = ~mode;
      b = tx_q[i / 8];
      mosi = b[7 - (i % 8)];
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(8);
      bf = {bf[6:0], miso_f};
      br = {br[6:0], miso_r};
      sclk = 1'b0;
      wait_clk(4);
      if (i >= 8 && (i % 8) == 7) begin
        rx_f.push_back(bf);
        rx_r.push_back(br);
      end
    end
    wait_clk(8);
    cs = 1'b1;
    wait_clk(10);
  endtask

  // Reference model: decode the frame from the protocol rules and compare.
  task automatic model_check(input bit md, input int nbits);
    int          full;
    bit          is_wr;
    logic [6:0]  a;
    logic [31:0] exp_flat;
    full  = nbits / 8;
    is_wr = 1'b0;
    exp_strb.delete(); exp_ld.delete(); exp_rx.delete();
    if (md) begin
      for (int j = 0; j < full; j++) exp_ld.push_back(tx_q[j]);
    end else if (full >= 1) begin
      is_wr = tx_q[0][7];
      a     = tx_q[0][6:0];
      for (int j = 1; j < full; j++) begin
        if (is_wr) begin
          if (int'(a) < NR) begin
            mregs[int'(a)] = tx_q[j];
            exp_strb.push_back(4'(1 << int'(a)));
          end
        end else begin
          exp_rx.push_back((int'(a) < NR) ? mregs[int'(a)] : 8'h00);
        end
        a = a + 7'd1;
      end
    end
    for (int k = 0; k < NR; k++) exp_flat[k*8 +: 8] = mregs[k];
    check_eq("user_f", user_f, exp_flat);
    check_eq("user_r", user_r, exp_flat);
    check_eq("strobe_count_f", mon_strb_f.size(), exp_strb.size());
    check_eq("strobe_count_r", mon_strb_r.size(), exp_strb.size());
    for (int j = 0; j < exp_strb.size() && j < mon_strb_f.size(); j++)
      check_eq("strobe_f", mon_strb_f[j], exp_strb[j]);
    for (int j = 0; j < exp_strb.size() && j < mon_strb_r.size(); j++)
      check_eq("strobe_r", mon_strb_r[j], exp_strb[j]);
    check_eq("load_count_f", mon_ld_f.size(), exp_ld.size());
    check_eq("load_count_r", mon_ld_r.size(), exp_ld.size());
    for (int j = 0; j < exp_ld.size() && j < mon_ld_f.size(); j++)
      check_eq("load_word_f", mon_ld_f[j], exp_ld[j]);
    for (int j = 0; j < exp_ld.size() && j < mon_ld_r.size(); j++)
      check_eq("load_word_r", mon_ld_r[j], exp_ld[j]);
    if (md && full > 0) begin
      check_eq("instr_f", instr_f, tx_q[full-1]);
      check_eq("instr_r", instr_r, tx_q[full-1]);
    end
    if (!md && !is_wr && full > 1) begin
      for (int j = 0; j < exp_rx.size(); j++) begin
        check_eq("miso_byte_f", rx_f[j], exp_rx[j]);
        check_eq("miso_byte_r", rx_r[j], exp_rx[j]);
      end
    end
  endtask

  task automatic run_frame(input string name, input bit md, input int nbits, input int toggle_at);
    $display("frame %s: mode=%0b bits=%0d bytes=%0d first=%02h", name, md, nbits, tx_q.size(), tx_q[0]);
    do_frame(md, nbits, toggle_at, -1);
    model_check(md, nbits);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_user_f"}, user_f, 32'h0);
    check_eq({tag, "_user_r"}, user_r, 32'h0);
    check_eq({tag, "_miso_f"}, miso_f, 1'b0);
    check_eq({tag, "_miso_r"}, miso_r, 1'b0);
    check_eq({tag, "_instr_f"}, instr_f, 8'h00);
    check_eq({tag, "_instr_r"}, instr_r, 8'h00);
    check_eq({tag, "_pulses_f"}, {strb_f, load_f}, 5'h0);
    check_eq({tag, "_pulses_r"}, {strb_r, load_r}, 5'h0);
  endtask

  initial begin
    int         kind, n, nbits;
    bit         md;
    logic [6:0] a;

    for (int k = 0; k < NR; k++) mregs[k] = 8'h00;

    wait_clk(5);
    check_reset_state("reset");
    rst = 1'b0;
    wait_clk(5);

    tx_q = '{8'h82, 8'hA5};
    run_frame("write_r2", 1'b0, 16, -1);
    tx_q = '{8'h83, 8'h11, 8'h22};
    run_frame("burst_wrap", 1'b0, 24, -1);
    tx_q = '{8'h02, 8'h00};
    run_frame("read_r2", 1'b0, 16, -1);
    tx_q = '{8'h10, 8'h00};
    run_frame("read_oob", 1'b0, 16, -1);
    tx_q = '{8'h3C, 8'hF0};
    run_frame("stream", 1'b1, 16, 5);
    tx_q = '{8'h81, 8'hC3};
    run_frame("abort_r1", 1'b0, 13, -1);
    tx_q = '{8'h81, 8'h6E};
    run_frame("write_r1", 1'b0, 16, -1);
    tx_q = '{8'h80, 8'h99};
    run_frame("write_r0_toggle", 1'b0, 16, 3);
    tx_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("read_burst", 1'b0, 40, -1);

    tx_q = '{8'h81, 8'hFF};
    $display("frame reset_mid: mode=0 bits=11");
    do_frame(1'b0, 16, -1, 11);
    for (int k = 0; k < NR; k++) mregs[k] = 8'h00;
    check_reset_state("midreset");
    check_eq("midreset_strobes", mon_strb_f.size() + mon_strb_r.size(), 0);
    tx_q = '{8'h82, 8'h42};
    run_frame("write_after_reset", 1'b0, 16, -1);

    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 3);
      if (kind == 3) kind = 4 + $urandom_range(0, 2);
      n  = $urandom_range(1, 3);
      md = 1'b0;
      tx_q.delete();
      if ($urandom_range(0, 3) == 0) a = 7'(126 + $urandom_range(0, 1));
      else a = 7'($urandom_range(0, 7));
      case (kind % 4)
        0: tx_q.push_back({1'b1, a});
        1: tx_q.push_back({1'b0, a});
        default: md = 1'b1;
      endcase
      for (int j = 0; j < n; j++) tx_q.push_back(8'($urandom));
      nbits = 8 * tx_q.size();
      if (kind >= 4) nbits = $urandom_range(1, nbits - 1);
      run_frame($sformatf("rand%0d_k%0d", f, kind), md, nbits, int'($urandom_range(0, 40)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
